// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// Shared definitions for the UART RX command sequencer.
// Holds the opcode byte values, the FSM state encoding and the default
// register-file addresses used for ALU operands.
package uart_rx_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR_DEF = 0;
  localparam int OPB_ADDR_DEF = 1;

  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [ST_W-1:0] ST_WR_ADDR  = 4'd1;
  localparam logic [ST_W-1:0] ST_WR_DATA  = 4'd2;
  localparam logic [ST_W-1:0] ST_RD_ADDR  = 4'd3;
  localparam logic [ST_W-1:0] ST_RD_WAIT  = 4'd4;
  localparam logic [ST_W-1:0] ST_TX_RD    = 4'd5;
  localparam logic [ST_W-1:0] ST_ALU_OPA  = 4'd6;
  localparam logic [ST_W-1:0] ST_ALU_OPB  = 4'd7;
  localparam logic [ST_W-1:0] ST_ALU_FUN  = 4'd8;
  localparam logic [ST_W-1:0] ST_ALU_WAIT = 4'd9;
  localparam logic [ST_W-1:0] ST_TX_LO    = 4'd10;
  localparam logic [ST_W-1:0] ST_TX_HI    = 4'd11;

  typedef enum logic [ST_W-1:0] {
    S_IDLE     = ST_IDLE,
    S_WR_ADDR  = ST_WR_ADDR,
    S_WR_DATA  = ST_WR_DATA,
    S_RD_ADDR  = ST_RD_ADDR,
    S_RD_WAIT  = ST_RD_WAIT,
    S_TX_RD    = ST_TX_RD,
    S_ALU_OPA  = ST_ALU_OPA,
    S_ALU_OPB  = ST_ALU_OPB,
    S_ALU_FUN  = ST_ALU_FUN,
    S_ALU_WAIT = ST_ALU_WAIT,
    S_TX_LO    = ST_TX_LO,
    S_TX_HI    = ST_TX_HI
  } state_t;

  // States that never consume a received byte: any rx_valid here is lost.
  function automatic logic is_drop_state(state_t s);
    return s inside {S_RD_WAIT, S_ALU_WAIT, S_TX_RD, S_TX_LO, S_TX_HI};
  endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Bus bundle between the command sequencer and its surroundings:
// UART RX byte stream, register file, ALU (+ clock gate) and TX FIFO.
//   master : the sequencer (drives strobes, consumes rx/rf/alu/tx status)
//   slave  : the environment (RX, register file, ALU, TX FIFO)
interface uart_rx_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
);
  logic                  rx_valid;
  logic [DATA_W-1:0]     rx_data;
  logic                  rf_wr_en;
  logic                  rf_rd_en;
  logic [ADDR_W-1:0]     rf_addr;
  logic [DATA_W-1:0]     rf_wr_data;
  logic [DATA_W-1:0]     rf_rd_data;
  logic                  rf_rd_valid;
  logic                  alu_en;
  logic [FUN_W-1:0]      alu_fun;
  logic [2*DATA_W-1:0]   alu_out;
  logic                  alu_out_valid;
  logic                  clk_gate_en;
  logic                  tx_full;
  logic                  tx_wr_en;
  logic [DATA_W-1:0]     tx_wr_data;
  logic                  cmd_err;

  modport master (
    input  rx_valid, rx_data, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
           tx_wr_en, tx_wr_data, cmd_err
  );

  modport slave (
    output rx_valid, rx_data, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
           tx_wr_en, tx_wr_data, cmd_err
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl_tx_push.sv
// TX push sequencer: loads a 1- or 2-byte result on start and pushes it
// low byte first into the TX FIFO, one byte per cycle at most, only when
// tx_full was low on the deciding edge.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           load data_in/byte_cnt (only issued while idle)
//   byte_cnt        number of bytes to push (1 or 2)
//   data_in         result, low byte pushed first
//   tx_full         FIFO back-pressure
//   tx_wr_en/data   registered FIFO push
//   push_go         a byte is being committed this cycle
//   done            the last byte is being committed this cycle
module uart_rx_cmd_tx_push #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          byte_cnt,
  input  logic [2*DATA_W-1:0] data_in,
  input  logic                tx_full,
  output logic                tx_wr_en,
  output logic [DATA_W-1:0]   tx_wr_data,
  output logic                push_go,
  output logic                done
);
  logic                busy;
  logic [1:0]          left;
  logic [2*DATA_W-1:0] data_q;

  assign push_go = busy && !tx_full;
  assign done    = push_go && (left == 2'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      left       <= 2'd0;
      data_q     <= '0;
      tx_wr_en   <= 1'b0;
      tx_wr_data <= '0;
    end else begin
      tx_wr_en <= push_go;
      if (push_go) begin
        tx_wr_data <= data_q[DATA_W-1:0];
        data_q     <= data_q >> DATA_W;
        left       <= left - 2'd1;
        if (left == 2'd1) busy <= 1'b0;
      end else if (start) begin
        busy   <= 1'b1;
        left   <= byte_cnt;
        data_q <= data_in;
      end
    end
  end
endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// UART RX command sequencer. Decodes framed commands from the RX byte
// stream (opcode then operands), drives register-file writes/reads and
// ALU operand loads/starts, and returns read/ALU results through the TX
// FIFO via uart_rx_cmd_tx_push. All outputs are registered.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  master side of uart_rx_cmd_ctrl_if (rx, rf, alu, tx, cmd_err)
module uart_rx_cmd_ctrl
  import uart_rx_cmd_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int FUN_W    = 4,
  parameter int OPA_ADDR = OPA_ADDR_DEF,
  parameter int OPB_ADDR = OPB_ADDR_DEF
) (
  input logic                 clk,
  input logic                 rst,
  uart_rx_cmd_ctrl_if.master  bus
);
  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_nxt;
  logic                rf_wr_en_q, rf_wr_en_nxt;
  logic                rf_rd_en_q, rf_rd_en_nxt;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_nxt;
  logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_nxt;
  logic                alu_en_q, alu_en_nxt;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_nxt;
  logic                gate_q, gate_nxt;
  logic                err_q, err_nxt;
  logic                push_start;
  logic [1:0]          push_cnt;
  logic [2*DATA_W-1:0] push_data;
  logic                push_go, push_done;
  logic                tx_wr_en_w;
  logic [DATA_W-1:0]   tx_wr_data_w;

  always_comb begin
    state_nxt      = state;
    wr_addr_nxt    = wr_addr_q;
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = 1'b0;
    rf_addr_nxt    = rf_addr_q;
    rf_wr_data_nxt = rf_wr_data_q;
    alu_en_nxt     = 1'b0;
    alu_fun_nxt    = alu_fun_q;
    err_nxt        = is_drop_state(state) && bus.rx_valid;
    push_start     = 1'b0;
    push_cnt       = 2'd1;
    push_data      = '0;
    case (state)
      S_IDLE: if (bus.rx_valid) begin
        if      (bus.rx_data == DATA_W'(CMD_WR))      state_nxt = S_WR_ADDR;
        else if (bus.rx_data == DATA_W'(CMD_RD))      state_nxt = S_RD_ADDR;
        else if (bus.rx_data == DATA_W'(CMD_ALU_OP))  state_nxt = S_ALU_OPA;
        else if (bus.rx_data == DATA_W'(CMD_ALU_NOP)) state_nxt = S_ALU_FUN;
        else                                          err_nxt   = 1'b1;
      end
      S_WR_ADDR: if (bus.rx_valid) begin
        wr_addr_nxt = bus.rx_data[ADDR_W-1:0];
        state_nxt   = S_WR_DATA;
      end
      S_WR_DATA: if (bus.rx_valid) begin
        rf_wr_en_nxt   = 1'b1;
        rf_addr_nxt    = wr_addr_q;
        rf_wr_data_nxt = bus.rx_data;
        state_nxt      = S_IDLE;
      end
      S_RD_ADDR: if (bus.rx_valid) begin
        rf_rd_en_nxt = 1'b1;
        rf_addr_nxt  = bus.rx_data[ADDR_W-1:0];
        state_nxt    = S_RD_WAIT;
      end
      S_RD_WAIT: if (bus.rf_rd_valid) begin
        push_start = 1'b1;
        push_cnt   = 2'd1;
        push_data  = {{DATA_W{1'b0}}, bus.rf_rd_data};
        state_nxt  = S_TX_RD;
      end
      S_TX_RD: if (push_done) state_nxt = S_IDLE;
      S_ALU_OPA: if (bus.rx_valid) begin
        rf_wr_en_nxt   = 1'b1;
        rf_addr_nxt    = ADDR_W'(OPA_ADDR);
        rf_wr_data_nxt = bus.rx_data;
        state_nxt      = S_ALU_OPB;
      end
      S_ALU_OPB: if (bus.rx_valid) begin
        rf_wr_en_nxt   = 1'b1;
        rf_addr_nxt    = ADDR_W'(OPB_ADDR);
        rf_wr_data_nxt = bus.rx_data;
        state_nxt      = S_ALU_FUN;
      end
      S_ALU_FUN: if (bus.rx_valid) begin
        alu_en_nxt  = 1'b1;
        alu_fun_nxt = bus.rx_data[FUN_W-1:0];
        state_nxt   = S_ALU_WAIT;
      end
      S_ALU_WAIT: if (bus.alu_out_valid) begin
        push_start = 1'b1;
        push_cnt   = 2'd2;
        push_data  = bus.alu_out;
        state_nxt  = S_TX_LO;
      end
      // The low-byte commit moves us on; the pusher keeps the high byte.
      S_TX_LO: if (push_go) state_nxt = S_TX_HI;
      S_TX_HI: if (push_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Registered from the next state so the gate is high exactly while in
    // ALU_FUN/ALU_WAIT and drops on entry to TX_LO.
    gate_nxt = (state_nxt == S_ALU_FUN) || (state_nxt == S_ALU_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      wr_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      gate_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_addr_q    <= wr_addr_nxt;
      rf_wr_en_q   <= rf_wr_en_nxt;
      rf_rd_en_q   <= rf_rd_en_nxt;
      rf_addr_q    <= rf_addr_nxt;
      rf_wr_data_q <= rf_wr_data_nxt;
      alu_en_q     <= alu_en_nxt;
      alu_fun_q    <= alu_fun_nxt;
      gate_q       <= gate_nxt;
      err_q        <= err_nxt;
    end
  end

  uart_rx_cmd_tx_push #(.DATA_W(DATA_W)) u_tx_push (
    .clk        (clk),
    .rst        (rst),
    .start      (push_start),
    .byte_cnt   (push_cnt),
    .data_in    (push_data),
    .tx_full    (bus.tx_full),
    .tx_wr_en   (tx_wr_en_w),
    .tx_wr_data (tx_wr_data_w),
    .push_go    (push_go),
    .done       (push_done)
  );

  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = gate_q;
  assign bus.cmd_err     = err_q;
  assign bus.tx_wr_en    = tx_wr_en_w;
  assign bus.tx_wr_data  = tx_wr_data_w;
endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Testbench for uart_rx_cmd_ctrl: table of command frames with their
// expected register-file, ALU and TX activity, plus hand-written
// sequences for reset mid-frame and a byte colliding with a read return.
module tb_uart_rx_cmd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_cmd_ctrl_if #(.DATA_W(8), .ADDR_W(4), .FUN_W(4)) bus ();

  uart_rx_cmd_ctrl #(.DATA_W(8), .ADDR_W(4), .FUN_W(4), .OPA_ADDR(0), .OPB_ADDR(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Scoreboard queues, filled when stimulus is driven.
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  fun_q[$];
  logic [7:0]  tx_q[$];
  int err_seen = 0;
  int tx_seen  = 0;
  logic full_q = 1'b0;
  logic p_wr = 1'b0, p_rd = 1'b0, p_alu = 1'b0, p_tx = 1'b0, p_err = 1'b0;

  always @(posedge clk) full_q <= bus.tx_full;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.rf_wr_en) begin
        chk("wr_one_cycle", p_wr, 0);
        if (wr_q.size() == 0) chk("wr_expected", wr_q.size(), 1);
        else chk("rf_wr", {bus.rf_addr, bus.rf_wr_data}, wr_q.pop_front());
      end
      if (bus.rf_rd_en) begin
        chk("rd_one_cycle", p_rd, 0);
        if (rd_q.size() == 0) chk("rd_expected", rd_q.size(), 1);
        else chk("rf_rd_addr", bus.rf_addr, rd_q.pop_front());
      end
      if (bus.alu_en) begin
        chk("alu_one_cycle", p_alu, 0);
        chk("gate_at_alu_en", bus.clk_gate_en, 1);
        if (fun_q.size() == 0) chk("alu_expected", fun_q.size(), 1);
        else chk("alu_fun", bus.alu_fun, fun_q.pop_front());
      end
      if (bus.tx_wr_en) begin
        tx_seen++;
        chk("tx_full_respected", full_q, 0);
        if (tx_q.size() == 0) chk("tx_expected", tx_q.size(), 1);
        else chk("tx_data", bus.tx_wr_data, tx_q.pop_front());
      end
      if (bus.cmd_err) begin
        chk("err_one_cycle", p_err, 0);
        err_seen++;
      end
      p_wr <= bus.rf_wr_en; p_rd <= bus.rf_rd_en; p_alu <= bus.alu_en;
      p_tx <= bus.tx_wr_en; p_err <= bus.cmd_err;
    end else begin
      p_wr <= 1'b0; p_rd <= 1'b0; p_alu <= 1'b0; p_tx <= 1'b0; p_err <= 1'b0;
    end
  end

  typedef struct {
    int n; logic [7:0] b0, b1, b2, b3;
    logic [7:0] rd; logic [15:0] alu; int stall; bit junk;
    int e_err; int e_wr_n; logic [3:0] wa0; logic [7:0] wd0; logic [3:0] wa1; logic [7:0] wd1;
    bit e_rd; logic [3:0] e_ra; bit e_alu; logic [3:0] e_fun;
    int e_tx_n; logic [7:0] tx0, tx1;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3,
                              input logic [7:0] rd, input logic [15:0] alu, input int stall,
                              input bit junk, input int e_err, input int e_wr_n,
                              input logic [3:0] wa0, input logic [7:0] wd0,
                              input logic [3:0] wa1, input logic [7:0] wd1,
                              input bit e_rd, input logic [3:0] e_ra,
                              input bit e_alu, input logic [3:0] e_fun,
                              input int e_tx_n, input logic [7:0] tx0, tx1);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
    v.rd = rd; v.alu = alu; v.stall = stall; v.junk = junk;
    v.e_err = e_err; v.e_wr_n = e_wr_n; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.e_rd = e_rd; v.e_ra = e_ra; v.e_alu = e_alu; v.e_fun = e_fun;
    v.e_tx_n = e_tx_n; v.tx0 = tx0; v.tx1 = tx1;
    return v;
  endfunction

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1; bus.rx_data = b;
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size()) != 0 && k < 100) begin
      tick();
      k++;
    end
    chk(name, wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rf_wr_en"}, bus.rf_wr_en, 0);
    chk({tag, "_rf_rd_en"}, bus.rf_rd_en, 0);
    chk({tag, "_rf_addr"}, bus.rf_addr, 0);
    chk({tag, "_rf_wr_data"}, bus.rf_wr_data, 0);
    chk({tag, "_alu_en"}, bus.alu_en, 0);
    chk({tag, "_alu_fun"}, bus.alu_fun, 0);
    chk({tag, "_clk_gate_en"}, bus.clk_gate_en, 0);
    chk({tag, "_tx_wr_en"}, bus.tx_wr_en, 0);
    chk({tag, "_tx_wr_data"}, bus.tx_wr_data, 0);
    chk({tag, "_cmd_err"}, bus.cmd_err, 0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [7:0] bs [4];
    int base_err, base_tx;
    bs[0] = v.b0; bs[1] = v.b1; bs[2] = v.b2; bs[3] = v.b3;
    base_err = err_seen;
    if (v.e_wr_n > 0) wr_q.push_back({v.wa0, v.wd0});
    if (v.e_wr_n > 1) wr_q.push_back({v.wa1, v.wd1});
    if (v.e_rd) rd_q.push_back(v.e_ra);
    if (v.e_alu) fun_q.push_back(v.e_fun);
    if (v.e_tx_n > 0) tx_q.push_back(v.tx0);
    if (v.e_tx_n > 1) tx_q.push_back(v.tx1);
    for (int i = 0; i < v.n; i++) begin
      if (v.e_alu) chk($sformatf("v%0d_gate_b%0d", k, i), bus.clk_gate_en, (i == v.n - 1) ? 1 : 0);
      send_byte(bs[i]);
    end
    if (v.e_rd) begin
      bus.rf_rd_data = v.rd; bus.rf_rd_valid = 1'b1; bus.tx_full = (v.stall > 0);
      tick();
      bus.rf_rd_valid = 1'b0;
    end
    if (v.e_alu) begin
      if (v.junk) send_byte(8'h77);
      chk($sformatf("v%0d_gate_wait", k), bus.clk_gate_en, 1);
      bus.alu_out = v.alu; bus.alu_out_valid = 1'b1; bus.tx_full = (v.stall > 0);
      tick();
      bus.alu_out_valid = 1'b0;
    end
    if (v.stall > 0) begin
      base_tx = tx_seen;
      repeat (v.stall) tick();
      chk($sformatf("v%0d_no_push_while_full", k), tx_seen - base_tx, 0);
      bus.tx_full = 1'b0;
    end
    drain($sformatf("v%0d_drain", k));
    repeat (3) tick();
    chk($sformatf("v%0d_cmd_err_count", k), err_seen - base_err, v.e_err);
    if (v.e_alu) chk($sformatf("v%0d_gate_after", k), bus.clk_gate_en, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_err;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    bus.rf_rd_data = '0; bus.rf_rd_valid = 1'b0;
    bus.alu_out = '0; bus.alu_out_valid = 1'b0;
    bus.tx_full = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b1;
    tick();

    //          n  b0     b1     b2     b3     rd     alu       st jk err wrn wa0   wd0    wa1   wd1    rd ra    alu fun   txn tx0    tx1
    vecs[0] = mk(3, 8'hAA, 8'h05, 8'h3C, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 1, 4'h5, 8'h3C, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
    vecs[1] = mk(2, 8'hBB, 8'h05, 8'h00, 8'h00, 8'h3C, 16'h0000, 10, 0, 0, 0, 4'h0, 8'h00, 4'h0, 8'h00, 1, 4'h5, 0, 4'h0, 1, 8'h3C, 8'h00);
    vecs[2] = mk(4, 8'hCC, 8'h07, 8'h03, 8'h00, 8'h00, 16'h000A, 0, 0, 0, 2, 4'h0, 8'h07, 4'h1, 8'h03, 0, 4'h0, 1, 4'h0, 2, 8'h0A, 8'h00);
    vecs[3] = mk(2, 8'hDD, 8'h02, 8'h00, 8'h00, 8'h00, 16'h1234, 3, 0, 0, 0, 4'h0, 8'h00, 4'h0, 8'h00, 0, 4'h0, 1, 4'h2, 2, 8'h34, 8'h12);
    vecs[4] = mk(1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 1, 0, 4'h0, 8'h00, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
    vecs[5] = mk(2, 8'hDD, 8'h03, 8'h00, 8'h00, 8'h00, 16'hBEEF, 0, 1, 1, 0, 4'h0, 8'h00, 4'h0, 8'h00, 0, 4'h0, 1, 4'h3, 2, 8'hEF, 8'hBE);
    vecs[6] = mk(3, 8'hAA, 8'h0F, 8'hFF, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 1, 4'hF, 8'hFF, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
    vecs[7] = mk(2, 8'hBB, 8'h1A, 8'h00, 8'h00, 8'h80, 16'h0000, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 8'h00, 1, 4'hA, 0, 4'h0, 1, 8'h80, 8'h00);
    vecs[8] = mk(2, 8'hDD, 8'h1F, 8'h00, 8'h00, 8'h00, 16'hFFFF, 1, 0, 0, 0, 4'h0, 8'h00, 4'h0, 8'h00, 0, 4'h0, 1, 4'hF, 2, 8'hFF, 8'hFF);
    vecs[9] = mk(4, 8'hCC, 8'hFF, 8'h80, 8'h05, 8'h00, 16'h8001, 2, 0, 0, 2, 4'h0, 8'hFF, 4'h1, 8'h80, 0, 4'h0, 1, 4'h5, 2, 8'h01, 8'h80);

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

    // Reset in the middle of a write frame: the half frame must be forgotten.
    send_byte(8'hAA);
    send_byte(8'h05);
    rst = 1'b0;
    #2;
    check_zero("midwr");
    tick();
    rst = 1'b1;
    tick();
    base_err = err_seen;
    wr_q.push_back({4'h6, 8'h11});
    send_byte(8'hAA); send_byte(8'h06); send_byte(8'h11);
    drain("midwr_drain");
    repeat (3) tick();
    chk("midwr_err", err_seen - base_err, 0);

    // Reset while waiting for the ALU: gate and alu_fun must clear.
    fun_q.push_back(4'h1);
    send_byte(8'hDD); send_byte(8'h01);
    chk("midalu_gate_before", bus.clk_gate_en, 1);
    rst = 1'b0;
    #2;
    check_zero("midalu");
    tick();
    rst = 1'b1;
    tick();
    drain("midalu_drain");

    // rx byte in the same cycle as the read return: byte dropped with cmd_err.
    base_err = err_seen;
    rd_q.push_back(4'h2);
    tx_q.push_back(8'h5A);
    send_byte(8'hBB); send_byte(8'h02);
    bus.rx_valid = 1'b1; bus.rx_data = 8'hAA;
    bus.rf_rd_valid = 1'b1; bus.rf_rd_data = 8'h5A;
    tick();
    bus.rx_valid = 1'b0; bus.rf_rd_valid = 1'b0;
    drain("collide_drain");
    repeat (3) tick();
    chk("collide_err", err_seen - base_err, 1);
    wr_q.push_back({4'h3, 8'h44});
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h44);
    drain("after_collide_drain");
    repeat (3) tick();
    chk("after_collide_err", err_seen - base_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cmd_ctrl.md
Name: uart_rx_cmd_ctrl

Overview:
- Command sequencer between the UART receiver and the system resources: register file, ALU with its clock gate, and the TX FIFO.
- Consumes received bytes and decodes framed commands (opcode followed by operands).
- Issues register-file writes and reads, loads ALU operands and triggers ALU operations.
- Pushes read and ALU results into the TX FIFO, honouring FIFO back-pressure.

Parameters:
- DATA_W, 8, width of the RX byte, register-file data and TX FIFO data.
- ADDR_W, 4, register-file address width; taken from rx_data[ADDR_W-1:0].
- FUN_W, 4, ALU function width; taken from rx_data[FUN_W-1:0].
- OPA_ADDR, 0, register-file address that receives ALU operand A.
- OPB_ADDR, 1, register-file address that receives ALU operand B.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  single-cycle pulse; rx_data is valid (already synchronised to clk).
- rx_data  in  DATA_W  received byte.
- rf_wr_en  out  1  register-file write strobe, 1 cycle.
- rf_rd_en  out  1  register-file read strobe, 1 cycle.
- rf_addr  out  ADDR_W  register-file address.
- rf_wr_data  out  DATA_W  register-file write data.
- rf_rd_data  in  DATA_W  register-file read data.
- rf_rd_valid  in  1  rf_rd_data is valid, 1-cycle pulse.
- alu_en  out  1  ALU start strobe, 1 cycle.
- alu_fun  out  FUN_W  ALU function, held stable while in ALU states.
- alu_out  in  2*DATA_W  ALU result.
- alu_out_valid  in  1  ALU result is valid, 1-cycle pulse.
- clk_gate_en  out  1  ALU clock-gate enable.
- tx_full  in  1  TX FIFO full.
- tx_wr_en  out  1  TX FIFO push, 1 cycle.
- tx_wr_data  out  DATA_W  TX FIFO push data.
- cmd_err  out  1  1-cycle pulse for an unknown opcode or a dropped byte.

Behaviour:
- Reset: every output register is 0; state is IDLE.
- All outputs are registered. Each strobe asserts the cycle after its triggering input and lasts exactly 1 cycle.
- Opcodes, taken as rx_data in IDLE:
  - 0xAA write: 2 more bytes, addr then data.
  - 0xBB read: 1 more byte, addr.
  - 0xCC ALU with operands: 3 more bytes, A, B, fun.
  - 0xDD ALU without operands: 1 more byte, fun.
- Any other byte in IDLE: pulse cmd_err, remain in IDLE.
- States and transitions:
  - IDLE -> WR_ADDR, RD_ADDR, ALU_OPA or ALU_FUN on rx_valid with a legal opcode.
  - WR_ADDR: rx_valid latches the address -> WR_DATA.
  - WR_DATA: rx_valid -> rf_wr_en=1 with the latched addr and rf_wr_data=rx_data -> IDLE.
  - RD_ADDR: rx_valid -> rf_rd_en=1, rf_addr=rx_data -> RD_WAIT.
  - RD_WAIT: rf_rd_valid latches rf_rd_data -> TX_RD.
  - TX_RD: while tx_full=0 -> tx_wr_en=1 with the latched byte -> IDLE. While tx_full=1, wait with tx_wr_en=0.
  - ALU_OPA: rx_valid -> rf_wr_en with rf_addr=OPA_ADDR -> ALU_OPB.
  - ALU_OPB: rx_valid -> rf_wr_en with rf_addr=OPB_ADDR -> ALU_FUN.
  - ALU_FUN: clk_gate_en=1 while in this state. rx_valid -> alu_en=1, alu_fun=rx_data[FUN_W-1:0] -> ALU_WAIT.
  - ALU_WAIT: clk_gate_en=1. alu_out_valid latches all 2*DATA_W bits -> TX_LO.
  - TX_LO: pushes the low byte when tx_full=0 -> TX_HI.
  - TX_HI: pushes the high byte when tx_full=0 -> IDLE. clk_gate_en drops on entry to TX_LO.
- Byte dropping: rx_valid arriving in RD_WAIT, ALU_WAIT, TX_RD, TX_LO or TX_HI is dropped and pulses cmd_err. The state is unaffected.
- Timeouts: none. RD_WAIT and ALU_WAIT wait indefinitely.
- Simultaneous events: an rx_valid that arrives in the same cycle as a state's completing event is dropped (cmd_err) unless the state is IDLE.
- Back-pressure: at most one TX push per cycle; never push while tx_full=1.
- Reset mid-frame: returns to IDLE immediately, clears all strobes and the latched address/result, and deasserts clk_gate_en.

Decomposition:
- Shared package holds:
  - opcode constants CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD;
  - the state encoding as localparams;
  - OPA_ADDR and OPB_ADDR defaults.
- One sub-module is natural: uart_rx_cmd_tx_push. It takes a 1- or 2-byte result plus a byte count and a start pulse, and sequences the pushes against tx_full. It returns done.

Test Plan:
- Write: AA,05,3C -> one rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C; return to IDLE; cmd_err never asserted.
- Read with back-pressure: BB,05, rf_rd_data=0x3C with tx_full held 1 for 10 cycles -> rf_rd_en with rf_addr=5; tx_wr_en=0 during the 10 cycles, then a single push of 0x3C.
- ALU with operands: CC,07,03,00, alu_out=0x000A -> writes addr0=7 and addr1=3; alu_en with alu_fun=0; clk_gate_en high from ALU_FUN through ALU_WAIT; pushes 0x0A then 0x00.
- ALU without operands: DD,02 -> no rf_wr_en; alu_en with alu_fun=2; two TX pushes.
- Errors: unknown opcode 0x55 -> cmd_err pulse, state stays IDLE. A byte sent during ALU_WAIT -> cmd_err pulse; the following frame is still decoded correctly.
- Reset mid-frame: assert rst after AA,05 -> all outputs 0; a subsequent AA,06,11 writes addr 6 only.
